sr_latch_bank: RTL and testbench

Parametrised, synchronous bank of `WIDTH` independent set/reset storage channels. It replaces single-bit gate-level SR latches wherever a design needs clocked, glitch-free SR state. Conflict handling for S=R=1 is selectable at elaboration. The block tracks illegal/conflict activity with sticky per-channel flags and a saturating event counter.

---
 rtl/sr_latch_bank_if.sv | 38 +++
 rtl/sr_latch_bank.sv | 90 +++++++++
 tb/tb_sr_latch_bank.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sr_latch_bank_if.sv
// Bundle of the SR bank's control inputs and state outputs.
// The master side drives enable, set/reset requests and flag clearing;
// the slave side (the latch bank) returns channel state and conflict status.
interface sr_latch_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             clr_flags;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] conflict;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output en,
        output s,
        output r,
        output clr_flags,
        input  q,
        input  qn,
        input  conflict,
        input  conflict_cnt
    );

    modport slave (
        input  en,
        input  s,
        input  r,
        input  clr_flags,
        output q,
        output qn,
        output conflict,
        output conflict_cnt
    );
endinterface

// File: rtl/sr_latch_bank.sv
// Clocked bank of independent set/reset channels with elaboration-time
// selectable S=R=1 resolution, sticky per-channel conflict flags and a
// saturating count of cycles in which any channel saw a conflict.
// MODE: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle.
module sr_latch_bank #(
    parameter int               WIDTH = 8,
    parameter int               MODE  = 0,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    sr_latch_bank_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_conflict;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_qNext;
    logic [WIDTH-1:0] w_hit;
    logic             w_anyHit;

    assign w_hit    = {WIDTH{bus.en}} & bus.s & bus.r;
    assign w_anyHit = |w_hit;

    // Per-channel next state: hold by default, apply set/reset when enabled,
    // and resolve S=R=1 according to the elaborated MODE.
    always_comb begin
        w_qNext = r_q;
        if (bus.en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({bus.s[i], bus.r[i]})
                    2'b10:   w_qNext[i] = 1'b1;
                    2'b01:   w_qNext[i] = 1'b0;
                    2'b11: begin
                        case (MODE)
                            0:       w_qNext[i] = 1'b0;
                            1:       w_qNext[i] = 1'b1;
                            3:       w_qNext[i] = ~r_q[i];
                            default: w_qNext[i] = r_q[i];
                        endcase
                    end
                    default: w_qNext[i] = r_q[i];
                endcase
            end
        end
    end

    // Channel state register; clr_flags deliberately has no effect here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= INIT;
        end else begin
            r_q <= w_qNext;
        end
    end

    // Sticky conflict flags; a same-cycle hit survives a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict <= '0;
        end else if (bus.clr_flags) begin
            r_conflict <= w_hit;
        end else begin
            r_conflict <= r_conflict | w_hit;
        end
    end

    // Saturating count of conflict cycles, one step per cycle regardless of
    // how many channels collide; a clear with a hit restarts at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (bus.clr_flags) begin
            r_cnt <= w_anyHit ? CNT_ONE : '0;
        end else if (w_anyHit && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign bus.q            = r_q;
    assign bus.qn           = ~r_q;
    assign bus.conflict     = r_conflict;
    assign bus.conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed testbench for sr_latch_bank: four instances (one per MODE) share
// the same stimulus so conflict resolution can be compared side by side.
// All instances use WIDTH=4, INIT=4'b1010 and a 2-bit counter so that
// saturation is reached quickly.
module tb_sr_latch_bank;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       clrFlags;

    int checkCount;
    int errorCount;

    sr_latch_bank_if #(.WIDTH(4), .CNT_W(2)) bus0 ();
    sr_latch_bank_if #(.WIDTH(4), .CNT_W(2)) bus1 ();
    sr_latch_bank_if #(.WIDTH(4), .CNT_W(2)) bus2 ();
    sr_latch_bank_if #(.WIDTH(4), .CNT_W(2)) bus3 ();

    assign bus0.en = en;  assign bus0.s = s;  assign bus0.r = r;  assign bus0.clr_flags = clrFlags;
    assign bus1.en = en;  assign bus1.s = s;  assign bus1.r = r;  assign bus1.clr_flags = clrFlags;
    assign bus2.en = en;  assign bus2.s = s;  assign bus2.r = r;  assign bus2.clr_flags = clrFlags;
    assign bus3.en = en;  assign bus3.s = s;  assign bus3.r = r;  assign bus3.clr_flags = clrFlags;

    sr_latch_bank #(.WIDTH(4), .MODE(0), .INIT(4'b1010), .CNT_W(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    sr_latch_bank #(.WIDTH(4), .MODE(1), .INIT(4'b1010), .CNT_W(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    sr_latch_bank #(.WIDTH(4), .MODE(2), .INIT(4'b1010), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    sr_latch_bank #(.WIDTH(4), .MODE(3), .INIT(4'b1010), .CNT_W(2)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs away from the edge, then wait until just after
    // the rising edge that samples them so outputs can be checked.
    task automatic applyStimulus(input logic enV, input logic [3:0] sV, input logic [3:0] rV, input logic clrV);
        @(negedge clk);
        en       = enV;
        s        = sV;
        r        = rV;
        clrFlags = clrV;
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence with hand-computed expectations.
    initial begin
        checkCount = 0;
        errorCount = 0;
        en = 1'b0; s = 4'b0; r = 4'b0; clrFlags = 1'b0;
        reset = 1'b1;
        #2;
        checkOutput("rst_q0",    32'(bus0.q), 32'h a);
        checkOutput("rst_qn0",   32'(bus0.qn), 32'h5);
        checkOutput("rst_conf0", 32'(bus0.conflict), 32'h0);
        checkOutput("rst_cnt0",  32'(bus0.conflict_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic set/reset from a cleared state.
        applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b0);
        checkOutput("clr_all_q0", 32'(bus0.q), 32'h0);
        applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0);
        checkOutput("set_q0", 32'(bus0.q), 32'h1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        checkOutput("hold_q0", 32'(bus0.q), 32'h1);
        checkOutput("hold_qn0", 32'(bus0.qn), 32'he);
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b0);
        checkOutput("reset_q0", 32'(bus0.q), 32'h0);
        checkOutput("noconf0", 32'(bus0.conflict), 32'h0);

        // Mode sweep from q=0101 with s=r=1111 for two cycles.
        applyStimulus(1'b1, 4'b0101, 4'b1010, 1'b0);
        checkOutput("pre_q3", 32'(bus3.q), 32'h5);
        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0);
        checkOutput("m0_q",    32'(bus0.q), 32'h0);
        checkOutput("m1_q",    32'(bus1.q), 32'hf);
        checkOutput("m2_q",    32'(bus2.q), 32'h5);
        checkOutput("m3_q",    32'(bus3.q), 32'ha);
        checkOutput("m3_qn",   32'(bus3.qn), 32'h5);
        checkOutput("m0_conf", 32'(bus0.conflict), 32'hf);
        checkOutput("m1_conf", 32'(bus1.conflict), 32'hf);
        checkOutput("m2_conf", 32'(bus2.conflict), 32'hf);
        checkOutput("m3_conf", 32'(bus3.conflict), 32'hf);
        checkOutput("m0_cnt",  32'(bus0.conflict_cnt), 32'h1);
        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0);
        checkOutput("m3_q2",   32'(bus3.q), 32'h5);
        checkOutput("m2_q2",   32'(bus2.q), 32'h5);
        checkOutput("m1_q2",   32'(bus1.q), 32'hf);
        checkOutput("m3_cnt2", 32'(bus3.conflict_cnt), 32'h2);

        // Clear flags with no hit, then enable gating with s=r=1111.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        checkOutput("clr_cnt",  32'(bus0.conflict_cnt), 32'h0);
        checkOutput("clr_conf", 32'(bus0.conflict), 32'h0);
        checkOutput("clr_keepq3", 32'(bus3.q), 32'h5);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b0);
            checkOutput("gate_q3",   32'(bus3.q), 32'h5);
            checkOutput("gate_q0",   32'(bus0.q), 32'h0);
            checkOutput("gate_conf", 32'(bus3.conflict), 32'h0);
            checkOutput("gate_cnt",  32'(bus3.conflict_cnt), 32'h0);
        end

        // Counter saturation: five consecutive hits on channel 0.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b0);
            checkOutput("sat_cnt", 32'(bus0.conflict_cnt), (k < 3) ? 32'(k + 1) : 32'h3);
        end
        checkOutput("sat_conf", 32'(bus0.conflict), 32'h1);

        // Clear without hit, then clear with a hit on channel 2.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        checkOutput("clr2_cnt",  32'(bus0.conflict_cnt), 32'h0);
        checkOutput("clr2_conf", 32'(bus0.conflict), 32'h0);
        applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b1);
        checkOutput("clrhit_cnt",  32'(bus1.conflict_cnt), 32'h1);
        checkOutput("clrhit_conf", 32'(bus1.conflict), 32'h4);

        // All channels conflicting in one cycle count once.
        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0);
        checkOutput("multi_cnt",  32'(bus1.conflict_cnt), 32'h2);
        checkOutput("multi_conf", 32'(bus1.conflict), 32'hf);

        // Mid-cycle reset takes effect without a clock edge.
        @(negedge clk);
        en = 1'b0; s = 4'b0; r = 4'b0; clrFlags = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_q1",    32'(bus1.q), 32'ha);
        checkOutput("mid_qn1",   32'(bus1.qn), 32'h5);
        checkOutput("mid_conf1", 32'(bus1.conflict), 32'h0);
        checkOutput("mid_cnt1",  32'(bus1.conflict_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        checkOutput("post_q1", 32'(bus1.q), 32'ha);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
